// File: rtl/inst_memory_loadable.sv
// Loadable instruction memory for the fetch stage.
// After reset the array is swept with FILL_WORD, then programs are streamed in
// through a valid/ready load port. busy stalls fetch while the array is owned
// by the fill sweep or by a load session.
module inst_memory_loadable #(
  parameter int unsigned           PC_SIZE    = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = {DATA_WIDTH{1'b1}},
  parameter bit                    REG_READ   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_SIZE-1:0]    PCF,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  rd_valid,
  output logic                  busy,
  input  logic                  ld_start,
  input  logic [PC_SIZE-1:0]    ld_base,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic [PC_SIZE:0]      ld_count,
  output logic                  ld_overflow
);

  localparam int unsigned DEPTH = 1 << PC_SIZE;
  localparam int unsigned CW    = PC_SIZE + 1;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [PC_SIZE-1:0]    fill_ptr;
  logic [PC_SIZE-1:0]    ld_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  fill_done_c;
  logic                  beat_c;
  logic                  room_c;
  logic                  we_c;
  logic [PC_SIZE-1:0]    waddr_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // A beat is any valid cycle while a session is open; room says it can still be stored.
  assign fill_done_c = (fill_ptr == PC_SIZE'(DEPTH - 1));
  assign beat_c      = (state == S_LOAD) && ld_valid;
  assign room_c      = (ld_count != CW'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: fill sweep, then idle, then load sessions on request.
  always_comb begin
    state_nx = state;
    case (state)
      S_FILL: begin
        if (fill_done_c) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (ld_start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (beat_c && ld_last) state_nx = S_IDLE;
      end
      default: state_nx = S_FILL;
    endcase
  end

  // Single write port shared by the fill sweep and load beats.
  always_comb begin
    we_c    = 1'b0;
    waddr_c = fill_ptr;
    wdata_c = FILL_WORD;
    if (state == S_FILL) begin
      we_c = 1'b1;
    end else if (beat_c && room_c) begin
      we_c    = 1'b1;
      waddr_c = ld_ptr;
      wdata_c = ld_data;
    end
  end

  // Storage array; contents are defined by the post-reset sweep, not by reset itself.
  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b1;
      ld_ready <= 1'b0;
    end else begin
      busy     <= (state_nx != S_IDLE);
      ld_ready <= (state_nx == S_LOAD);
    end
  end

  // Fill sweep pointer; only advances while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr <= '0;
    end else if (state == S_FILL) begin
      fill_ptr <= fill_ptr + PC_SIZE'(1);
    end
  end

  // Load session bookkeeping: pointer wraps, count saturates at DEPTH, overflow is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr      <= '0;
      ld_count    <= '0;
      ld_overflow <= 1'b0;
    end else if ((state == S_IDLE) && ld_start) begin
      ld_ptr      <= ld_base;
      ld_count    <= '0;
      ld_overflow <= 1'b0;
    end else if (beat_c) begin
      if (room_c) begin
        ld_ptr   <= ld_ptr + PC_SIZE'(1);
        ld_count <= ld_count + CW'(1);
      end else begin
        ld_overflow <= 1'b1;
      end
    end
  end

  generate
    if (REG_READ) begin : g_reg_read
      // Registered fetch: served only in idle, RD holds when no fetch is served.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          RD       <= FILL_WORD;
          rd_valid <= 1'b0;
        end else if ((state == S_IDLE) && fetch_en) begin
          RD       <= mem[PCF];
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end else begin : g_comb_read
      // Combinational fetch masked while the array is owned by fill or load.
      logic unused_fetch_en;
      assign unused_fetch_en = fetch_en;
      assign RD       = busy ? FILL_WORD : mem[PCF];
      assign rd_valid = ~busy;
    end
  endgenerate

endmodule

// File: tb/tb_inst_memory_loadable.sv
// Bench for inst_memory_loadable: a 256-word combinational-read instance and a
// 16-word registered-read instance share one stimulus stream and are checked
// every cycle against a behavioural model, plus literal spot checks.
module tb_inst_memory_loadable;

  localparam logic [31:0] FW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  pcf;
  logic [7:0]  ld_base;
  logic        fetch_en, ld_start, ld_valid, ld_last;
  logic [31:0] ld_data;

  logic [31:0] a_rd, b_rd;
  logic        a_rdv, b_rdv, a_busy, b_busy, a_rdy, b_rdy, a_ovf, b_ovf;
  logic [8:0]  a_cnt;
  logic [4:0]  b_cnt;

  always #5 clk = ~clk;

  inst_memory_loadable #(.PC_SIZE(8), .DATA_WIDTH(32), .FILL_WORD(FW), .REG_READ(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .PCF(pcf), .fetch_en(fetch_en), .RD(a_rd), .rd_valid(a_rdv),
    .busy(a_busy), .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(a_rdy), .ld_count(a_cnt),
    .ld_overflow(a_ovf)
  );

  inst_memory_loadable #(.PC_SIZE(4), .DATA_WIDTH(32), .FILL_WORD(FW), .REG_READ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .PCF(pcf[3:0]), .fetch_en(fetch_en), .RD(b_rd), .rd_valid(b_rdv),
    .busy(b_busy), .ld_start(ld_start), .ld_base(ld_base[3:0]), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_rdy), .ld_count(b_cnt),
    .ld_overflow(b_ovf)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int cyc = 0;
  int rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
  int unsigned m_depth [2] = '{256, 16};
  bit          m_rr    [2] = '{1'b0, 1'b1};
  logic [31:0] m_mem   [2][256];
  int          m_fill_left [2];
  bit          m_loading [2];
  int          m_ptr [2];
  int          m_cnt [2];
  bit          m_ovf [2];
  logic [31:0] m_rd  [2];
  bit          m_rdv [2];

  initial begin : model
    bit idle;
    int a;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          m_fill_left[d] = int'(m_depth[d]);
          m_loading[d] = 1'b0;
          m_cnt[d] = 0;
          m_ovf[d] = 1'b0;
          m_rd[d] = FW;
          m_rdv[d] = 1'b0;
        end else begin
          idle = (m_fill_left[d] == 0) && !m_loading[d];
          a = int'(pcf) % int'(m_depth[d]);
          if (idle && fetch_en) begin
            m_rd[d] = m_mem[d][a];
            m_rdv[d] = 1'b1;
          end else begin
            m_rdv[d] = 1'b0;
          end
          if (m_fill_left[d] > 0) begin
            m_mem[d][int'(m_depth[d]) - m_fill_left[d]] = FW;
            m_fill_left[d]--;
          end else if (m_loading[d]) begin
            if (ld_valid) begin
              if (m_cnt[d] < int'(m_depth[d])) begin
                m_mem[d][m_ptr[d]] = ld_data;
                m_ptr[d] = (m_ptr[d] + 1) % int'(m_depth[d]);
                m_cnt[d]++;
              end else begin
                m_ovf[d] = 1'b1;
              end
              if (ld_last) m_loading[d] = 1'b0;
            end
          end else if (ld_start) begin
            m_loading[d] = 1'b1;
            m_ptr[d] = int'(ld_base) % int'(m_depth[d]);
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input string nm, input logic busy, input logic rdy,
                         input logic rdv, input logic [31:0] rd, input logic [8:0] cnt,
                         input logic ovf);
    bit busy_e;
    logic [31:0] rd_e;
    busy_e = (m_fill_left[d] > 0) || m_loading[d];
    if (m_rr[d]) rd_e = m_rd[d];
    else rd_e = busy_e ? FW : m_mem[d][int'(pcf) % int'(m_depth[d])];
    chk({nm, ".busy"}, 64'(busy), 64'(busy_e));
    chk({nm, ".ld_ready"}, 64'(rdy), 64'(m_loading[d]));
    chk({nm, ".rd_valid"}, 64'(rdv), m_rr[d] ? 64'(m_rdv[d]) : 64'(!busy_e));
    chk({nm, ".RD"}, 64'(rd), 64'(rd_e));
    chk({nm, ".ld_count"}, 64'(cnt), 64'(m_cnt[d]));
    chk({nm, ".ld_overflow"}, 64'(ovf), 64'(m_ovf[d]));
  endtask

  // Every-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_on) begin
        cmp_dut(0, "A", a_busy, a_rdy, a_rdv, a_rd, a_cnt, a_ovf);
        cmp_dut(1, "B", b_busy, b_rdy, b_rdv, b_rd, {4'd0, b_cnt}, b_ovf);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle_in();
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_fill(input string nm);
    int guard;
    guard = 0;
    do begin
      tick();
      look();
      guard++;
    end while (a_busy && guard < 400);
    chk(nm, 64'(cyc - rel_cyc), 64'd256);
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] prog [6] = '{32'h8C010000, 32'h8C020001, 32'h00221820,
                            32'h00000000, 32'h00000000, 32'hAC030003};

  initial begin : stim
    pcf = '0; ld_base = '0; ld_data = '0;
    idle_in();
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) tick();
    look();
    chk("reset A.busy", 64'(a_busy), 64'd1);
    chk("reset A.rd_valid", 64'(a_rdv), 64'd0);
    chk("reset A.RD", 64'(a_rd), 64'(FW));
    chk("reset B.RD", 64'(b_rd), 64'(FW));
    chk("reset B.ld_ready", 64'(b_rdy), 64'd0);
    tick();
    rst_n = 1'b1;
    rel_cyc = cyc;

    // ld_start while both instances are still filling must be ignored
    tick(); ld_start = 1'b1; ld_base = 8'd5;
    tick(); ld_start = 1'b0;
    repeat (20) tick();
    look();
    chk("B idle after fill", 64'(b_busy), 64'd0);
    chk("B start in fill ignored", 64'(b_rdy), 64'd0);

    // wrap-around load on B with gapped beats
    tick(); ld_base = 8'd14; ld_start = 1'b1;
    tick(); ld_start = 1'b0;
    beat(32'hAAAA0001, 1'b0); tick();
    beat(32'hBBBB0002, 1'b0); tick();
    beat(32'hCCCC0003, 1'b1);
    look();
    chk("B wrap ld_count", 64'(b_cnt), 64'd3);
    chk("B wrap ld_overflow", 64'(b_ovf), 64'd0);

    // registered fetch latency and hold
    tick(); pcf = 8'd14; fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    look();
    chk("B fetch 14 RD", 64'(b_rd), 64'h00000000AAAA0001);
    chk("B fetch 14 rd_valid", 64'(b_rdv), 64'd1);
    tick(); look();
    chk("B idle fetch rd_valid", 64'(b_rdv), 64'd0);
    chk("B idle fetch RD held", 64'(b_rd), 64'h00000000AAAA0001);
    tick(); pcf = 8'd0; fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    look();
    chk("B fetch 0 RD", 64'(b_rd), 64'h00000000CCCC0003);

    // overflow on B: 17 beats into 16 words
    tick(); ld_base = 8'd0; ld_start = 1'b1;
    tick(); ld_start = 1'b0;
    for (int i = 0; i < 17; i++) beat($urandom, 1'(i == 16));
    look();
    chk("B ovf ld_count", 64'(b_cnt), 64'd16);
    chk("B ovf sticky", 64'(b_ovf), 64'd1);
    tick(); ld_start = 1'b1;
    tick(); ld_start = 1'b0;
    look();
    chk("B ovf cleared", 64'(b_ovf), 64'd0);
    tick();
    beat(32'h12345678, 1'b1);

    // A fill length and fill contents
    wait_fill("A fill length");
    foreach (prog[i]) begin end
    tick(); pcf = 8'd0;   look(); chk("A RD 0 fill", 64'(a_rd), 64'(FW));
    tick(); pcf = 8'd17;  look(); chk("A RD 17 fill", 64'(a_rd), 64'(FW));
    tick(); pcf = 8'd255; look(); chk("A RD 255 fill", 64'(a_rd), 64'(FW));
    chk("A rd_valid idle", 64'(a_rdv), 64'd1);

    // program load on A
    tick(); ld_base = 8'd0; ld_start = 1'b1;
    tick(); ld_start = 1'b0;
    for (int i = 0; i < 6; i++) beat(prog[i], 1'(i == 5));
    look();
    chk("A prog ld_count", 64'(a_cnt), 64'd6);
    chk("A prog busy", 64'(a_busy), 64'd0);
    tick(); pcf = 8'd0; look(); chk("A RD 0 prog", 64'(a_rd), 64'h000000008C010000);
    tick(); pcf = 8'd5; look(); chk("A RD 5 prog", 64'(a_rd), 64'h00000000AC030003);
    tick(); pcf = 8'd6; look(); chk("A RD 6 prog", 64'(a_rd), 64'(FW));

    // randomized traffic checked by the model
    repeat (500) begin
      tick();
      pcf = 8'($urandom); ld_base = 8'($urandom); ld_data = $urandom;
      fetch_en = 1'($urandom_range(0, 1));
      ld_start = 1'($urandom_range(0, 11) == 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_last  = 1'($urandom_range(0, 19) == 0);
    end
    tick(); idle_in(); ld_valid = 1'b1; ld_last = 1'b1;
    tick(); idle_in();
    tick();

    // reset in the middle of a load session
    ld_base = 8'h10; ld_start = 1'b1;
    tick(); ld_start = 1'b0;
    for (int i = 0; i < 3; i++) beat($urandom, 1'b0);
    #1 rst_n = 1'b0;
    look();
    chk("midload reset A.busy", 64'(a_busy), 64'd1);
    chk("midload reset A.ld_count", 64'(a_cnt), 64'd0);
    chk("midload reset B.ld_count", 64'(b_cnt), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_fill("A refill length");
    chk("A ld_count after refill", 64'(a_cnt), 64'd0);
    for (int i = 0; i < 256; i++) begin
      tick(); pcf = 8'(i); fetch_en = 1'b1;
      look();
      chk("A refill RD", 64'(a_rd), 64'(FW));
    end
    tick(); idle_in();
    tick(); look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_memory_loadable.md
Name: inst_memory_loadable

Overview:
Parametrised instruction memory for the pipeline fetch stage: word-addressed by PCF, one instruction word per address.
- Unlike the fixed initial-block ROM, contents are cleared to a fill word by hardware after reset.
- Contents are then loaded at run time through a valid/ready streaming port, so programs change without re-elaboration.
- Optional registered read port for timing closure.
- A busy flag stalls fetch while the memory is being filled or loaded.

Parameters:
PC_SIZE, 8, address width; DEPTH = 1 << PC_SIZE words.
DATA_WIDTH, 32, instruction word width.
FILL_WORD, {DATA_WIDTH{1'b1}}, word written to every location after reset (garbage/illegal instruction).
REG_READ, 0, 0 = combinational read; 1 = one-cycle registered read.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
PCF  in  PC_SIZE  fetch address
fetch_en  in  1  fetch request; used only when REG_READ=1
RD  out  DATA_WIDTH  instruction word
rd_valid  out  1  RD is valid for the current/last fetch
busy  out  1  fill or load in progress; core must stall fetch
ld_start  in  1  pulse: begin load session at ld_base
ld_base  in  PC_SIZE  first load address, sampled with ld_start
ld_valid  in  1  load beat valid
ld_data  in  DATA_WIDTH  load beat data
ld_last  in  1  marks final beat of the session
ld_ready  out  1  memory accepts a load beat
ld_count  out  PC_SIZE+1  beats written in the current/last session
ld_overflow  out  1  sticky: a beat was dropped because DEPTH words were already written

Behaviour:
- FSM states: FILL, IDLE, LOAD.
- Reset (rst_n=0, asynchronous):
  - state=FILL, fill_ptr=0, busy=1, rd_valid=0, ld_ready=0, ld_count=0, ld_overflow=0.
  - Registered RD = FILL_WORD.
  - Memory array is not reset directly.
- FILL:
  - One write per cycle, mem[fill_ptr] <= FILL_WORD, fill_ptr++.
  - After the write at DEPTH-1 (exactly DEPTH cycles after reset release), go to IDLE.
  - ld_start, ld_valid and fetch_en are ignored.
- IDLE:
  - busy=0, ld_ready=0.
  - ld_start=1 -> LOAD next cycle; ld_ptr <= ld_base, ld_count <= 0, ld_overflow <= 0.
- LOAD:
  - busy=1, ld_ready=1.
  - Each cycle with ld_valid && ld_ready is a beat.
  - Beat with ld_count < DEPTH: mem[ld_ptr] <= ld_data; ld_ptr <= ld_ptr+1 (wraps DEPTH-1 -> 0); ld_count++.
  - Beat with ld_count == DEPTH: data dropped, ld_overflow <= 1, ld_count holds.
  - Beat with ld_last=1 (written or dropped): go to IDLE next cycle.
  - ld_start is ignored in LOAD.
  - ld_valid=0 cycles: no state change, no timeout.
- Read, REG_READ=0:
  - RD = busy ? FILL_WORD : mem[PCF], combinational.
  - rd_valid = ~busy.
  - A word written by the final beat is readable in the first IDLE cycle.
- Read, REG_READ=1:
  - In IDLE with fetch_en=1: RD <= mem[PCF], rd_valid <= 1 on the next edge.
  - fetch_en=0, or state not IDLE: rd_valid <= 0 and RD holds its value.
  - Latency is 1 cycle from fetch_en.
- ld_count and ld_overflow hold their values after returning to IDLE until the next ld_start.
- Simultaneous write and read of the same address in a LOAD cycle: no read is served (busy=1).
- Reset asserted mid-LOAD or mid-FILL:
  - Session aborts and the full FILL sequence restarts.
  - Any previously loaded contents are overwritten with FILL_WORD.

Test Plan:
1. Reset release, REG_READ=0, DEPTH=256 -> busy=1 for exactly 256 cycles, then busy=0; RD at PCF=0, 17, 255 = 32'hFFFFFFFF; rd_valid=1.
2. IDLE, ld_start with ld_base=0, then 6 beats (words of program: lw r1,0(r0) = 32'h8C010000 ... sw r3,3(r0) = 32'hAC030003), ld_last on beat 6 -> ld_count=6, IDLE; RD at PCF=0 = 32'h8C010000; PCF=5 = 32'hAC030003; PCF=6 = 32'hFFFFFFFF.
3. PC_SIZE=4: ld_base=14, 3 beats A,B,C with ld_valid gapped by one idle cycle each -> mem[14]=A, mem[15]=B, mem[0]=C, ld_count=3, ld_overflow=0.
4. PC_SIZE=4: ld_base=0, 17 beats, ld_last on 17th -> all 16 words written, 17th dropped, ld_count=16, ld_overflow=1; the next ld_start clears ld_overflow to 0.
5. REG_READ=1: fetch_en pulse with PCF=2 after load -> RD=mem[2] and rd_valid=1 exactly one cycle later; fetch_en=0 next cycle -> rd_valid=0, RD unchanged; ld_start during FILL -> no LOAD entered.
6. Drop rst_n after 3 load beats -> busy stays 1, FILL restarts from 0; after 256 cycles all addresses read FILL_WORD, ld_count=0.
